st_fwd_queue: RTL and testbench

In-order circular store queue with store-to-load forwarding. It sits between dispatch/AGU and the data-cache write port, and feeds the load reservation station.
- Allocates stores at dispatch and captures address/data from the AGU.
- Marks stores committed in program order and drains committed stores to memory over a req/ack handshake.
- Answers combinational forwarding lookups for one issuing load against the older stores that load depends on.

---
 rtl/st_fwd_queue.sv | 231 +++++++++++++++++++++++
 tb/tb_st_fwd_queue.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_fwd_queue.sv
`default_nettype none
// ============================================================================
// Module   : st_fwd_queue
// Brief    : In-order circular store queue with commit/drain handshake and
//            combinational store-to-load forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module st_fwd_queue #(
    parameter int ST_Q_ENTRIES = 8,
    parameter int ROB_IDX_W    = 5,
    parameter int IDX_W        = $clog2(ST_Q_ENTRIES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [2:0]              disp_funct3,
    input  logic [ROB_IDX_W-1:0]    disp_rob_idx,
    output logic [IDX_W-1:0]        disp_idx,
    input  logic                    agu_valid,
    input  logic [IDX_W-1:0]        agu_idx,
    input  logic [31:0]             agu_addr,
    input  logic [31:0]             agu_data,
    input  logic                    commit_valid,
    input  logic                    flush,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    output logic [3:0]              mem_wmask,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_ack,
    input  logic                    ld_valid,
    input  logic [31:0]             ld_addr,
    input  logic [2:0]              ld_funct3,
    input  logic [ST_Q_ENTRIES-1:0] ld_st_mask,
    output logic                    fwd_hit,
    output logic [31:0]             fwd_data,
    output logic                    fwd_stall,
    output logic [ST_Q_ENTRIES-1:0] occupied,
    output logic [IDX_W:0]          count
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} drain_state_t;

    localparam logic [IDX_W:0]   c_FULL_COUNT = (IDX_W+1)'(ST_Q_ENTRIES);
    localparam logic [IDX_W-1:0] c_IDX_ONE    = IDX_W'(1);

    logic [ST_Q_ENTRIES-1:0] r_valid, r_addr_valid, r_committed;
    logic [2:0]              r_funct3    [ST_Q_ENTRIES];
    logic [ROB_IDX_W-1:0]    r_rob_idx   [ST_Q_ENTRIES];
    logic [29:0]             r_waddr     [ST_Q_ENTRIES];
    logic [3:0]              r_wmask     [ST_Q_ENTRIES];
    logic [31:0]             r_wdata     [ST_Q_ENTRIES];
    logic [IDX_W-1:0]        r_head, r_tail, r_commit_ptr;
    logic [IDX_W:0]          r_count;
    drain_state_t            r_state, w_state_nxt;
    logic [31:0]             r_mem_addr, r_mem_wdata;
    logic [3:0]              r_mem_wmask;

    logic                    w_disp_fire, w_dealloc, w_head_ready, w_agu_ok;
    logic [3:0]              w_agu_base, w_agu_mask;
    logic [ST_Q_ENTRIES-1:0] w_keep;
    logic [IDX_W:0]          w_kept_count, w_fire_ext, w_dealloc_ext;
    logic [3:0]              w_ld_base, w_ld_mask;
    logic [ST_Q_ENTRIES-1:0] w_cand;
    logic                    w_pending, w_sel_found;
    logic [IDX_W-1:0]        w_sel_idx;
    logic [31:0]             w_shift;
    logic                    w_unused;

    assign disp_ready   = (r_count != c_FULL_COUNT) && !flush;
    assign disp_idx     = r_tail;
    assign occupied     = r_valid;
    assign count        = r_count;
    assign mem_addr     = r_mem_addr;
    assign mem_wmask    = r_mem_wmask;
    assign mem_wdata    = r_mem_wdata;
    assign w_disp_fire  = disp_valid && disp_ready;
    assign w_head_ready = r_valid[r_head] && r_committed[r_head] && r_addr_valid[r_head];
    assign w_fire_ext    = {{IDX_W{1'b0}}, w_disp_fire};
    assign w_dealloc_ext = {{IDX_W{1'b0}}, w_dealloc};

    always_comb begin
        case (r_funct3[agu_idx][1:0])
            2'b00:   w_agu_base = 4'b0001;
            2'b01:   w_agu_base = 4'b0011;
            default: w_agu_base = 4'b1111;
        endcase
        w_agu_mask = w_agu_base << agu_addr[1:0];
    end

    // An entry survives flush if already committed or being committed now.
    always_comb begin
        w_kept_count = '0;
        w_unused     = 1'b0;
        for (int i = 0; i < ST_Q_ENTRIES; i++) begin
            w_keep[i] = r_committed[i] || (commit_valid && (r_commit_ptr == IDX_W'(i)));
            if (r_valid[i] && w_keep[i])
                w_kept_count = w_kept_count + (IDX_W+1)'(1);
            w_unused = w_unused ^ (^r_rob_idx[i]) ^ r_funct3[i][2];
        end
    end

    assign w_agu_ok = agu_valid && r_valid[agu_idx] && !(flush && !w_keep[agu_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_addr_valid <= '0;
            r_committed  <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_commit_ptr <= '0;
            r_count      <= '0;
        end else begin
            if (w_disp_fire) begin
                r_valid[r_tail]      <= 1'b1;
                r_addr_valid[r_tail] <= 1'b0;
                r_committed[r_tail]  <= 1'b0;
                r_funct3[r_tail]     <= disp_funct3;
                r_rob_idx[r_tail]    <= disp_rob_idx;
                r_tail               <= r_tail + c_IDX_ONE;
            end
            if (w_agu_ok) begin
                r_addr_valid[agu_idx] <= 1'b1;
                r_waddr[agu_idx]      <= agu_addr[31:2];
                r_wmask[agu_idx]      <= w_agu_mask;
                r_wdata[agu_idx]      <= agu_data << {agu_addr[1:0], 3'b000};
            end
            if (commit_valid) begin
                r_committed[r_commit_ptr] <= 1'b1;
                r_commit_ptr              <= r_commit_ptr + c_IDX_ONE;
            end
            if (w_dealloc) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_IDX_ONE;
            end
            if (flush) begin
                for (int i = 0; i < ST_Q_ENTRIES; i++)
                    if (!w_keep[i]) r_valid[i] <= 1'b0;
                r_tail  <= r_commit_ptr + {{(IDX_W-1){1'b0}}, commit_valid};
                r_count <= w_kept_count - w_dealloc_ext;
            end else begin
                r_count <= r_count + w_fire_ext - w_dealloc_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        w_dealloc   = 1'b0;
        case (r_state)
            S_IDLE: if (w_head_ready) w_state_nxt = S_REQ;
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_dealloc   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request fields are captured on the IDLE->REQ edge and held until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wmask <= '0;
            r_mem_wdata <= '0;
        end else if (r_state == S_IDLE && w_head_ready) begin
            r_mem_addr  <= {r_waddr[r_head], 2'b00};
            r_mem_wmask <= r_wmask[r_head];
            r_mem_wdata <= r_wdata[r_head];
        end
    end

    always_comb begin
        case (ld_funct3[1:0])
            2'b00:   w_ld_base = 4'b0001;
            2'b01:   w_ld_base = 4'b0011;
            default: w_ld_base = 4'b1111;
        endcase
        w_ld_mask   = w_ld_base << ld_addr[1:0];
        w_cand      = ld_st_mask & r_valid;
        w_pending   = |(w_cand & ~r_addr_valid);
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        // Walk oldest to youngest so the last match is the youngest store.
        for (int k = 0; k < ST_Q_ENTRIES; k++) begin
            if (w_cand[r_head + IDX_W'(k)] &&
                (r_waddr[r_head + IDX_W'(k)] == ld_addr[31:2]) &&
                (|(r_wmask[r_head + IDX_W'(k)] & w_ld_mask))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = r_head + IDX_W'(k);
            end
        end
        w_shift   = r_wdata[w_sel_idx] >> {ld_addr[1:0], 3'b000};
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        if (ld_valid) begin
            if (w_pending) begin
                fwd_stall = 1'b1;
            end else if (w_sel_found) begin
                if ((r_wmask[w_sel_idx] & w_ld_mask) == w_ld_mask) begin
                    fwd_hit = 1'b1;
                    case (ld_funct3)
                        3'b000:  fwd_data = {{24{w_shift[7]}}, w_shift[7:0]};
                        3'b001:  fwd_data = {{16{w_shift[15]}}, w_shift[15:0]};
                        3'b100:  fwd_data = {24'b0, w_shift[7:0]};
                        3'b101:  fwd_data = {16'b0, w_shift[15:0]};
                        default: fwd_data = w_shift;
                    endcase
                end else begin
                    fwd_stall = 1'b1;
                end
            end
        end
    end

    a_commit_valid_entry: assert property (@(posedge clk) disable iff (rst)
        commit_valid |-> r_valid[r_commit_ptr]);

endmodule
`default_nettype wire

// File: tb/tb_st_fwd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_st_fwd_queue
// Brief    : Randomized scoreboard bench for st_fwd_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_st_fwd_queue;
    localparam int N  = 8;
    localparam int RW = 5;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst, disp_valid, disp_ready, agu_valid, commit_valid, flush;
    logic mem_req, mem_ack, ld_valid, fwd_hit, fwd_stall;
    logic [2:0] disp_funct3, ld_funct3;
    logic [RW-1:0] disp_rob_idx;
    logic [IW-1:0] disp_idx, agu_idx;
    logic [31:0] agu_addr, agu_data, mem_addr, mem_wdata, ld_addr, fwd_data;
    logic [3:0] mem_wmask;
    logic [N-1:0] ld_st_mask, occupied;
    logic [IW:0] count;

    always #5 clk = ~clk;

    st_fwd_queue #(.ST_Q_ENTRIES(N), .ROB_IDX_W(RW)) dut (
        .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_funct3(disp_funct3), .disp_rob_idx(disp_rob_idx), .disp_idx(disp_idx),
        .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr), .agu_data(agu_data),
        .commit_valid(commit_valid), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .ld_valid(ld_valid),
        .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_st_mask(ld_st_mask), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .fwd_stall(fwd_stall), .occupied(occupied), .count(count)
    );

    typedef struct {int idx; bit av; bit cm; logic [2:0] f3; logic [31:0] addr; logic [31:0] data;} st_t;
    typedef struct {logic [31:0] addr; logic [3:0] mask; logic [31:0] data;} drain_t;
    typedef struct {bit hit; bit stall; logic [31:0] data;} fwd_t;

    st_t    mq[$];
    drain_t drain_q[$];
    fwd_t   fwd_q[$];
    int     m_tail = 0;
    int     vectors = 0, miscompares = 0;
    int     ack_delay = 0;
    bit     ack_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sz(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [3:0] bmask(input logic [31:0] a, input logic [2:0] f);
        logic [3:0] m = '0;
        int off = int'(a[1:0]);
        for (int b = 0; b < sz(f); b++) if (off + b < 4) m[off + b] = 1'b1;
        return m;
    endfunction

    function automatic logic [N-1:0] occ_model();
        logic [N-1:0] o = '0;
        foreach (mq[i]) o[mq[i].idx] = 1'b1;
        return o;
    endfunction

    function automatic int first_uncommitted();
        foreach (mq[i]) if (!mq[i].cm) return i;
        return -1;
    endfunction

    // Youngest overlapping older store decides; its bytes are read lane by lane.
    function automatic fwd_t fwd_model(input logic [31:0] la, input logic [2:0] lf, input logic [N-1:0] m);
        fwd_t r;
        int sel = -1;
        logic [3:0] lm = bmask(la, lf);
        logic [3:0] sm;
        logic [31:0] img, v;
        r.hit = 0; r.stall = 0; r.data = '0;
        foreach (mq[i]) if (m[mq[i].idx] && !mq[i].av) r.stall = 1;
        if (r.stall) return r;
        foreach (mq[i])
            if (m[mq[i].idx] && mq[i].addr[31:2] == la[31:2] && (bmask(mq[i].addr, mq[i].f3) & lm) != 0)
                sel = i;
        if (sel < 0) return r;
        sm = bmask(mq[sel].addr, mq[sel].f3);
        if ((sm & lm) != lm) begin r.stall = 1; return r; end
        img = mq[sel].data << (8 * int'(mq[sel].addr[1:0]));
        v = '0;
        for (int b = 0; b < sz(lf); b++) v[8*b +: 8] = img[8*(int'(la[1:0]) + b) +: 8];
        if (!lf[2] && sz(lf) < 4 && v[8*sz(lf)-1])
            for (int b = sz(lf); b < 4; b++) v[8*b +: 8] = 8'hFF;
        r.hit = 1; r.data = v;
        return r;
    endfunction

    task automatic model_update(input bit hs, input bit fire);
        int cp;
        drain_t d;
        st_t e;
        if (rst) begin mq.delete(); drain_q.delete(); m_tail = 0; return; end
        if (commit_valid) begin
            cp = first_uncommitted();
            if (cp >= 0) begin
                mq[cp].cm = 1;
                d.addr = {mq[cp].addr[31:2], 2'b00};
                d.mask = bmask(mq[cp].addr, mq[cp].f3);
                d.data = mq[cp].data << (8 * int'(mq[cp].addr[1:0]));
                drain_q.push_back(d);
            end
        end
        if (agu_valid)
            foreach (mq[i])
                if (mq[i].idx == int'(agu_idx) && !(flush && !mq[i].cm)) begin
                    mq[i].av = 1; mq[i].addr = agu_addr; mq[i].data = agu_data;
                end
        if (hs && mq.size() > 0) void'(mq.pop_front());
        if (fire) begin
            e.idx = m_tail; e.av = 0; e.cm = 0; e.f3 = disp_funct3; e.addr = '0; e.data = '0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % N;
        end
        if (flush) begin
            cp = first_uncommitted();
            if (cp >= 0) m_tail = mq[cp].idx;
            mq = mq.find(x) with (x.cm);
        end
    endtask

    task automatic clr();
        disp_valid = 0; disp_funct3 = 3'b010; disp_rob_idx = '0; agu_valid = 0; agu_idx = '0;
        agu_addr = '0; agu_data = '0; commit_valid = 0; flush = 0; ld_valid = 0; ld_addr = '0;
        ld_funct3 = 3'b010; ld_st_mask = '0;
    endtask

    // Called 1 time unit after a rising edge with this cycle's inputs applied.
    task automatic step();
        bit hs, fire;
        #1;
        hs   = mem_req && mem_ack;
        fire = disp_valid && !flush && mq.size() != N;
        chk("disp_ready", {31'b0, disp_ready}, {31'b0, (mq.size() != N) && !flush});
        chk("count", {28'b0, count}, mq.size());
        chk("disp_idx", {29'b0, disp_idx}, m_tail);
        chk("occupied", {24'b0, occupied}, {24'b0, occ_model()});
        if (ld_valid) fwd_q.push_back(fwd_model(ld_addr, ld_funct3, ld_st_mask));
        @(posedge clk);
        model_update(hs, fire);
        #1;
        clr();
    endtask

    function automatic logic [31:0] gen_addr(input logic [2:0] f);
        logic [31:0] base = ($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h1004;
        if (sz(f) == 4) return base;
        if (sz(f) == 2) return base + 32'(2 * $urandom_range(0, 1));
        return base + 32'($urandom_range(0, 3));
    endfunction

    task automatic dispatch(input logic [2:0] f, output int idx);
        idx = m_tail; disp_valid = 1; disp_funct3 = f; disp_rob_idx = RW'($urandom); step();
    endtask

    task automatic agu(input int idx, input logic [31:0] a, input logic [31:0] d);
        agu_valid = 1; agu_idx = IW'(idx); agu_addr = a; agu_data = d; step();
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f, input logic [N-1:0] m);
        ld_valid = 1; ld_addr = a; ld_funct3 = f; ld_st_mask = m; step();
    endtask

    task automatic drain_all();
        int guard = 0;
        int cp;
        ack_en = 1;
        while (mq.size() != 0 && guard < 300) begin
            cp = first_uncommitted();
            if (cp >= 0) begin
                if (!mq[cp].av) begin
                    agu_valid = 1; agu_idx = IW'(mq[cp].idx);
                    agu_addr = gen_addr(mq[cp].f3); agu_data = $urandom;
                end else begin
                    commit_valid = 1;
                end
            end
            step();
            guard++;
        end
        if (mq.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: got %0d entries left, expected 0", mq.size());
        end
    endtask

    // Ack responder: holds off ack_delay cycles after mem_req rises.
    initial begin
        int w = 0;
        mem_ack = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_req && !mem_ack && ack_en) begin
                if (w >= ack_delay) begin mem_ack = 1; w = 0; end
                else w++;
            end else begin
                mem_ack = 0; w = 0;
            end
        end
    end

    always @(negedge clk) begin
        fwd_t e;
        if (!rst && ld_valid) begin
            if (fwd_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL fwd_scoreboard: got a lookup, expected none queued");
            end else begin
                e = fwd_q.pop_front();
                chk("fwd_hit", {31'b0, fwd_hit}, {31'b0, e.hit});
                chk("fwd_stall", {31'b0, fwd_stall}, {31'b0, e.stall});
                chk("fwd_data", fwd_data, e.data);
            end
        end
    end

    logic        prev_req = 0;
    logic [31:0] prev_addr, prev_data;
    logic [3:0]  prev_mask;
    always @(negedge clk) begin
        drain_t e;
        if (!rst && mem_req) begin
            if (prev_req) begin
                chk("mem_addr_stable", mem_addr, prev_addr);
                chk("mem_wmask_stable", {28'b0, mem_wmask}, {28'b0, prev_mask});
                chk("mem_wdata_stable", mem_wdata, prev_data);
            end
            if (mem_ack) begin
                if (drain_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL drain_scoreboard: got drain 0x%0h, expected none", mem_addr);
                end else begin
                    e = drain_q.pop_front();
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, e.mask});
                    chk("mem_wdata", mem_wdata, e.data);
                end
            end
        end
        prev_req  = mem_req && !mem_ack && !rst;
        prev_addr = mem_addr; prev_mask = mem_wmask; prev_data = mem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, i1, i2, guard;
        clr();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_fwd_hit", {31'b0, fwd_hit}, 0);
        chk("rst_fwd_stall", {31'b0, fwd_stall}, 0);
        chk("rst_disp_ready", {31'b0, disp_ready}, 1);
        chk("rst_occupied", {24'b0, occupied}, 0);
        chk("rst_count", {28'b0, count}, 0);

        // Fill with drains held off; 9th dispatch must bounce.
        ack_en = 0;
        for (int k = 0; k < 9; k++) dispatch(3'b010, i0);
        chk("full_disp_ready", {31'b0, disp_ready}, 0);
        for (int k = 0; k < N; k++) agu(k, 32'h4000 + 32'(4 * k), $urandom);
        commit_valid = 1; step();
        ack_en = 1; ack_delay = 0;
        guard = 0;
        while (mq.size() == N && guard < 20) begin step(); guard++; end
        chk("after_ack_disp_ready", {31'b0, disp_ready}, 1);
        drain_all();

        // Sign/zero-extended byte forward out of a word store.
        dispatch(3'b010, i0); agu(i0, 32'h1000, 32'hDEADBEEF);
        ld_valid = 1; ld_addr = 32'h1003; ld_funct3 = 3'b000; ld_st_mask = N'(1) << i0;
        #1 chk("lb_fwd_data", fwd_data, 32'hFFFFFFDE);
        step();
        load(32'h1003, 3'b100, N'(1) << i0);
        // Partial coverage stalls; youngest of two same-word stores wins.
        dispatch(3'b000, i1); agu(i1, 32'h2001, 32'h000000AA);
        ld_valid = 1; ld_addr = 32'h2000; ld_funct3 = 3'b010; ld_st_mask = N'(1) << i1;
        #1 chk("partial_stall", {31'b0, fwd_stall}, 1);
        step();
        dispatch(3'b010, i1); agu(i1, 32'h3000, 32'h11111111);
        dispatch(3'b010, i2); agu(i2, 32'h3000, 32'h22222222);
        ld_valid = 1; ld_addr = 32'h3000; ld_funct3 = 3'b010; ld_st_mask = (N'(1) << i1) | (N'(1) << i2);
        #1 chk("youngest_fwd", fwd_data, 32'h22222222);
        step();
        // Address-unknown older store stalls only when in the mask.
        dispatch(3'b010, i0);
        load(32'h3000, 3'b010, N'(1) << i0);
        load(32'h3000, 3'b010, N'(1) << i2);
        drain_all();

        // Commit two of four, flush the rest, drain under slow ack.
        ack_en = 0; ack_delay = 3;
        for (int k = 0; k < 4; k++) begin
            dispatch(3'b010, i0); agu(i0, 32'h5000 + 32'(4 * k), $urandom);
        end
        commit_valid = 1; step();
        commit_valid = 1; step();
        flush = 1; step();
        chk("flush_count", {28'b0, count}, 2);
        ack_en = 1;
        drain_all();
        ack_delay = 0;

        // Randomized traffic, wrapping the ring many times.
        for (int c = 0; c < 1500; c++) begin
            int cp, pick;
            logic [2:0] lf3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            ack_en = 1; ack_delay = $urandom_range(0, 2);
            if ($urandom_range(0, 99) < 40) begin
                disp_valid = 1; disp_funct3 = 3'($urandom_range(0, 2)); disp_rob_idx = RW'($urandom);
            end
            if (mq.size() > 0 && $urandom_range(0, 99) < 50) begin
                pick = $urandom_range(0, mq.size() - 1);
                if (!mq[pick].av) begin
                    agu_valid = 1; agu_idx = IW'(mq[pick].idx);
                    agu_addr = gen_addr(mq[pick].f3); agu_data = $urandom;
                end
            end else if ($urandom_range(0, 99) < 5) begin
                agu_valid = 1; agu_idx = IW'($urandom); agu_addr = gen_addr(3'b010); agu_data = $urandom;
                if (occ_model()[agu_idx]) agu_valid = 0;
            end
            cp = first_uncommitted();
            if (cp >= 0 && mq[cp].av && $urandom_range(0, 99) < 30) commit_valid = 1;
            if ($urandom_range(0, 99) < 3) flush = 1;
            if ($urandom_range(0, 99) < 60) begin
                ld_valid = 1; ld_funct3 = lf3s[$urandom_range(0, 4)];
                ld_addr = gen_addr(ld_funct3); ld_st_mask = N'($urandom);
            end
            step();
        end
        drain_all();

        // Reset while a drain request is outstanding.
        ack_en = 0;
        dispatch(3'b010, i0); agu(i0, 32'h6000, 32'h12345678);
        commit_valid = 1; step();
        guard = 0;
        while (!mem_req && guard < 10) begin step(); guard++; end
        chk("req_before_rst", {31'b0, mem_req}, 1);
        rst = 1; step();
        #1;
        chk("rst_in_req_mem_req", {31'b0, mem_req}, 0);
        chk("rst_in_req_count", {28'b0, count}, 0);
        step();

        chk("fwd_q_empty", fwd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
